// File: rtl/int_ctrl.sv
// Vectored interrupt controller: synchronized request lines, per-line mask/edge
// configuration, lowest-index arbitration and a fixed idle gap after each acknowledge.
module int_ctrl #(
    parameter int unsigned N_IRQ    = 8,
    parameter logic [19:0] VEC_BASE = 20'h00100,
    parameter int unsigned GAP      = 2
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [N_IRQ-1:0] irq,
    output logic             int_in,
    output logic [19:0]      int_num,
    input  logic             int_ack,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [7:0]       cfg_wdata,
    output logic [7:0]       cfg_rdata
);

    localparam int unsigned REG_W = 8;
    localparam int unsigned VEC_W = 20;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] SEL_MASK = 2'd0;
    localparam logic [1:0] SEL_EDGE = 2'd1;
    localparam logic [1:0] SEL_PEND = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    logic [N_IRQ-1:0] sync1_q;
    logic [N_IRQ-1:0] sync2_q;
    logic [N_IRQ-1:0] sprev_q;

    logic [REG_W-1:0] mask_q, mask_d;
    logic [REG_W-1:0] edge_q, edge_d;
    logic [REG_W-1:0] pend_q, pend_d;

    state_e           state_q, state_d;
    logic             int_in_q, int_in_d;
    logic [VEC_W-1:0] int_num_q, int_num_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [REG_W-1:0] lvl;
    logic [REG_W-1:0] rise;
    logic [REG_W-1:0] clr;
    logic [REG_W-1:0] avail;
    logic [IDX_W-1:0] win_idx;

    // Two-flop synchronizer plus one extra stage for rising-edge detection
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sprev_q <= '0;
        end else begin
            sync1_q <= irq;
            sync2_q <= sync1_q;
            sprev_q <= sync2_q;
        end
    end

    // Pending/config next state; a same-cycle rising edge beats any clear
    always_comb begin
        lvl    = REG_W'(sync2_q);
        rise   = REG_W'(sync2_q & ~sprev_q);
        clr    = '0;
        mask_d = mask_q;
        edge_d = edge_q;
        if (cfg_we && (cfg_sel == SEL_PEND)) begin
            clr = cfg_wdata;
        end
        if ((state_q == S_REQ) && int_ack && edge_q[idx_q]) begin
            clr[idx_q] = 1'b1;
        end
        pend_d = (edge_q & ((pend_q & ~clr) | rise)) | (~edge_q & lvl);
        if (cfg_we) begin
            case (cfg_sel)
                SEL_MASK: mask_d = cfg_wdata;
                SEL_EDGE: edge_d = cfg_wdata;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mask_q <= '1;
            edge_q <= '0;
            pend_q <= '0;
        end else begin
            mask_q <= mask_d;
            edge_q <= edge_d;
            pend_q <= pend_d;
        end
    end

    // Lowest-index unmasked pending line
    always_comb begin
        avail   = pend_q & ~mask_q;
        win_idx = '0;
        for (int i = REG_W - 1; i >= 0; i--) begin
            if (avail[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= S_IDLE;
            int_in_q  <= 1'b0;
            int_num_q <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            int_in_q  <= int_in_d;
            int_num_q <= int_num_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
        end
    end

    // Request handshake: vector is frozen from grant until acknowledge
    always_comb begin
        state_d   = state_q;
        int_in_d  = int_in_q;
        int_num_d = int_num_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|avail) begin
                    state_d   = S_REQ;
                    int_in_d  = 1'b1;
                    idx_d     = win_idx;
                    int_num_d = VEC_BASE + VEC_W'(win_idx);
                end
            end
            S_REQ: begin
                if (int_ack) begin
                    state_d  = S_GAP;
                    int_in_d = 1'b0;
                    cnt_d    = CNT_W'(GAP - 1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d  = S_IDLE;
                int_in_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        case (cfg_sel)
            SEL_MASK: cfg_rdata = mask_q;
            SEL_EDGE: cfg_rdata = edge_q;
            SEL_PEND: cfg_rdata = pend_q;
            default:  cfg_rdata = '0;
        endcase
    end

    assign int_in  = int_in_q;
    assign int_num = int_num_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios with literal expectations plus a randomized
// run, all checked every cycle against a request/gap behavioural model.
module tb_int_ctrl;

    localparam int unsigned N_IRQ    = 8;
    localparam logic [19:0] VEC_BASE = 20'h00100;
    localparam int          GAP      = 2;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic [7:0]  irq = '0;
    logic        int_in;
    logic [19:0] int_num;
    logic        int_ack = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_sel = 2'd0;
    logic [7:0]  cfg_wdata = '0;
    logic [7:0]  cfg_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    int_ctrl #(.N_IRQ(N_IRQ), .VEC_BASE(VEC_BASE), .GAP(GAP)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .irq       (irq),
        .int_in    (int_in),
        .int_num   (int_num),
        .int_ack   (int_ack),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: sampled-irq history, pending bits, and request/gap timing
    logic [7:0]  m_mask, m_edge, m_pend;
    logic [7:0]  h0, h1, h2;
    logic        m_req;
    int          m_gap;
    logic [19:0] m_num;
    int          m_line;

    always @(posedge clk or negedge clr_n) begin : model
        logic [7:0]  clr, np, avail, lvl, rise;
        logic        req, found;
        int          gap, line;
        logic [19:0] num;
        if (!clr_n) begin
            m_mask <= 8'hFF; m_edge <= '0; m_pend <= '0;
            h0 <= '0; h1 <= '0; h2 <= '0;
            m_req <= 1'b0; m_gap <= 0; m_num <= '0; m_line <= 0;
        end else begin
            lvl  = h1;
            rise = h1 & ~h2;
            clr  = '0;
            if (cfg_we && cfg_sel == 2'd2) clr = cfg_wdata;
            if (m_req && int_ack && m_edge[m_line]) clr[m_line] = 1'b1;
            for (int i = 0; i < 8; i++)
                np[i] = m_edge[i] ? ((m_pend[i] & ~clr[i]) | rise[i]) : lvl[i];
            req = m_req; gap = m_gap; num = m_num; line = m_line;
            if (m_req) begin
                if (int_ack) begin
                    req = 1'b0;
                    gap = GAP;
                end
            end else if (m_gap > 0) begin
                gap = m_gap - 1;
            end else begin
                avail = m_pend & ~m_mask;
                found = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    if (avail[i] && !found) begin
                        found = 1'b1;
                        line  = i;
                    end
                end
                if (found) begin
                    req = 1'b1;
                    num = VEC_BASE + 20'(line);
                end
            end
            if (cfg_we && cfg_sel == 2'd0) m_mask <= cfg_wdata;
            if (cfg_we && cfg_sel == 2'd1) m_edge <= cfg_wdata;
            m_pend <= np;
            m_req  <= req;
            m_gap  <= gap;
            m_num  <= num;
            m_line <= line;
            h2 <= h1; h1 <= h0; h0 <= irq;
        end
    end

    function automatic logic [7:0] model_rdata(input logic [1:0] sel);
        case (sel)
            2'd0:    return m_mask;
            2'd1:    return m_edge;
            2'd2:    return m_pend;
            default: return 8'h00;
        endcase
    endfunction

    // Compare every cycle, mid-period
    always @(negedge clk) begin
        chk("int_in", 32'(int_in), 32'(m_req));
        chk("int_num", 32'(int_num), 32'(m_num));
        chk("cfg_rdata", 32'(cfg_rdata), 32'(model_rdata(cfg_sel)));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [7:0] d);
        cfg_sel = sel; cfg_wdata = d; cfg_we = 1'b1;
        cyc(1);
        cfg_we = 1'b0;
    endtask

    task automatic ack_pulse();
        int_ack = 1'b1;
        cyc(1);
        int_ack = 1'b0;
    endtask

    task automatic do_reset();
        irq = '0; int_ack = 1'b0; cfg_we = 1'b0; cfg_sel = 2'd0;
        clr_n = 1'b0;
        cyc(2);
        clr_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        do_reset();
        chk("rst_int_in", 32'(int_in), 32'd0);
        chk("rst_int_num", 32'(int_num), 32'd0);
        chk("rst_mask", 32'(cfg_rdata), 32'hFF);
        cfg_sel = 2'd1; #1 chk("rst_edge", 32'(cfg_rdata), 32'h00);
        cfg_sel = 2'd3; #1 chk("rst_reserved", 32'(cfg_rdata), 32'h00);
        cyc(1);

        // Basic level request on line 3, then re-request after the gap
        cfg_write(2'd0, 8'h00);
        irq = 8'h08;
        cyc(3); chk("basic_lat3", 32'(int_in), 32'd0);
        cyc(1); chk("basic_lat4", 32'(int_in), 32'd1);
        chk("basic_vec", 32'(int_num), 32'h00103);
        ack_pulse(); chk("basic_ackdrop", 32'(int_in), 32'd0);
        cyc(2); chk("basic_gap", 32'(int_in), 32'd0);
        cyc(1); chk("basic_rereq", 32'(int_in), 32'd1);
        ack_pulse(); irq = '0; cyc(6);

        // Priority: lines 1 and 5 rise together in edge mode
        do_reset();
        cfg_write(2'd1, 8'h22);
        cfg_write(2'd0, 8'h00);
        irq = 8'h22;
        cyc(4); chk("prio_first", 32'(int_num), 32'h00101);
        ack_pulse();
        cyc(3); chk("prio_second", 32'(int_num), 32'h00105);
        chk("prio_second_in", 32'(int_in), 32'd1);
        ack_pulse(); irq = '0; cyc(6);

        // Latched vector holds while a higher-priority line rises
        do_reset();
        cfg_write(2'd0, 8'h00);
        irq = 8'h10;
        cyc(4); chk("latch_vec", 32'(int_num), 32'h00104);
        irq = 8'h11;
        cyc(6); chk("latch_hold", 32'(int_num), 32'h00104);
        chk("latch_in", 32'(int_in), 32'd1);
        irq = 8'h01;
        cyc(2); chk("latch_leveldrop", 32'(int_in), 32'd1);
        ack_pulse(); irq = '0; cyc(6);

        // Edge set wins over acknowledge clear on line 2
        do_reset();
        cfg_write(2'd1, 8'h04);
        cfg_write(2'd0, 8'h00);
        irq = 8'h04; cyc(1);
        irq = 8'h00; cyc(1);
        irq = 8'h04; cyc(2);
        chk("setwins_req", 32'(int_num), 32'h00102);
        cfg_sel = 2'd2;
        ack_pulse();
        chk("setwins_pend", 32'(cfg_rdata), 32'h04);
        cyc(3); chk("setwins_rereq", 32'(int_in), 32'd1);
        chk("setwins_vec", 32'(int_num), 32'h00102);
        ack_pulse(); irq = '0; cyc(6);

        // Masked edge line latches PEND; W1C clears it
        do_reset();
        cfg_write(2'd1, 8'h01);
        cfg_write(2'd0, 8'h01);
        cfg_sel = 2'd2;
        irq = 8'h01; cyc(1);
        irq = 8'h00; cyc(5);
        chk("mask_noint", 32'(int_in), 32'd0);
        chk("mask_pend", 32'(cfg_rdata), 32'h01);
        cfg_write(2'd2, 8'h01);
        chk("w1c_pend", 32'(cfg_rdata), 32'h00);
        cyc(2);

        // Asynchronous reset while requesting
        do_reset();
        cfg_write(2'd0, 8'h00);
        irq = 8'h40;
        cyc(4); chk("rst_req_vec", 32'(int_num), 32'h00106);
        clr_n = 1'b0;
        #1 chk("rst_async_drop", 32'(int_in), 32'd0);
        cfg_sel = 2'd0;
        #1 chk("rst_async_mask", 32'(cfg_rdata), 32'hFF);
        cyc(1);
        clr_n = 1'b1;
        cyc(8); chk("rst_masked_quiet", 32'(int_in), 32'd0);
        cfg_write(2'd0, 8'h00);
        cyc(1); chk("rst_unmask_req", 32'(int_in), 32'd1);
        chk("rst_unmask_vec", 32'(int_num), 32'h00106);
        ack_pulse(); irq = '0; cyc(6);

        // Randomized traffic
        do_reset();
        cfg_write(2'd0, 8'h00);
        for (int c = 0; c < 3000; c++) begin
            irq     = irq ^ 8'($urandom & $urandom & $urandom);
            int_ack = ($urandom_range(0, 2) == 0);
            cfg_we  = ($urandom_range(0, 15) == 0);
            cfg_sel = 2'($urandom_range(0, 3));
            cfg_wdata = (cfg_sel == 2'd0) ? 8'($urandom & $urandom & $urandom) : 8'($urandom);
            if (c == 1500) begin
                clr_n = 1'b0;
                cyc(1);
                clr_n = 1'b1;
                cfg_we = 1'b1; cfg_sel = 2'd0; cfg_wdata = 8'h00;
            end
            cyc(1);
        end
        cfg_we = 1'b0; int_ack = 1'b0;
        cyc(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter N_IRQ, default 8, meaning number of request lines (1..8).
REQ-002 SHALL have parameter VEC_BASE, default 20'h00100, meaning vector number of line 0.
REQ-003 SHALL have parameter GAP, default 2, meaning idle cycles after each acknowledge (1..15).
REQ-004 SHALL use one clock and an asynchronous, active-low reset: port clk (input, 1) and port clr_n (input, 1, asynchronous, active-low).
REQ-005 SHALL have port irq, input, N_IRQ bits, meaning asynchronous device request lines.
REQ-006 SHALL have port int_in, output, 1 bit, meaning interrupt request to the CPU.
REQ-007 SHALL have port int_num, output, 20 bits, meaning vector number to the CPU.
REQ-008 SHALL have port int_ack, input, 1 bit, meaning one-cycle acknowledge pulse from the CPU.
REQ-009 SHALL have port cfg_we, input, 1 bit, meaning config write strobe.
REQ-010 SHALL have port cfg_sel, input, 2 bits, meaning register select: 0 = MASK, 1 = EDGE, 2 = PEND (W1C), 3 = reserved.
REQ-011 SHALL have port cfg_wdata, input, 8 bits, meaning config write data.
REQ-012 SHALL have port cfg_rdata, output, 8 bits, meaning combinational readback of the cfg_sel register; reserved reads 0.

Function
REQ-013 SHALL pass each irq bit through a 2-flop synchronizer before any use.
REQ-014 SHALL, for EDGE[i]=1, set PEND[i] on a synchronized 0->1 transition; for EDGE[i]=0, make PEND[i] equal the synchronized level.
REQ-015 SHALL latch PEND for masked lines (MASK[i]=1) and exclude them from arbitration only.
REQ-016 SHALL implement the states IDLE, REQ and GAP.
REQ-017 SHALL, in IDLE with any unmasked pending line, select the lowest index i, latch int_num = VEC_BASE + i (20-bit modulo), set int_in=1 and enter REQ on the next edge.
REQ-018 SHALL, in REQ, hold int_in=1 and int_num unchanged regardless of new requests, masking or PEND changes.
REQ-019 SHALL, in REQ with int_ack=1, drop int_in at the next edge, clear PEND of the latched line if it is edge-mode, and enter GAP.
REQ-020 SHALL, when a new edge on the acknowledged line coincides with its clear, keep PEND set (set wins).
REQ-021 SHALL stay in GAP for exactly GAP cycles with int_in=0, then return to IDLE; arbitration resumes in IDLE.
REQ-022 SHALL ignore int_ack in IDLE and GAP.
REQ-023 SHALL, in REQ, leave int_in asserted if the latched level line drops before acknowledge; the CPU receives the latched vector.
REQ-024 SHALL, on cfg_we, update MASK/EDGE at the next edge; PEND writes clear the bits written 1, with a same-cycle edge set winning.
REQ-025 SHALL make a config write that masks the latched line during REQ take effect only for the next arbitration.
REQ-026 SHALL give an irq to int_in latency of 4 cycles from the first sampling edge (2 sync, 1 PEND, 1 state register).
REQ-027 SHALL drive outputs only from registers, except cfg_rdata.

Reset
REQ-028 SHALL, while clr_n=0 (asynchronous), force state=IDLE, int_in=0, int_num=0, MASK=8'hFF (all masked), EDGE=0, PEND=0, synchronizers=0 and the GAP counter=0.
REQ-029 SHALL, when reset is asserted in REQ, drop int_in immediately without waiting for a clock edge.
REQ-030 SHALL begin sampling irq on the first edge after clr_n deasserts.

Verification
REQ-031 SHALL be verified for basic request: MASK=0, EDGE=0, irq[3] high -> after 4 cycles int_in=1, int_num=20'h00103; int_ack pulse -> int_in=0 next cycle; irq[3] still high -> int_in=1 again after 2 GAP cycles plus 1.
REQ-032 SHALL be verified for priority: irq[5] and irq[1] rising on the same cycle -> int_num=20'h00101 first; after acknowledge and GAP -> int_num=20'h00105.
REQ-033 SHALL be verified for latch stability: in REQ on line 4, irq[0] rises -> int_num stays 20'h00104 until int_ack.
REQ-034 SHALL be verified for edge set-wins: EDGE[2]=1, second edge on irq[2] arriving at PEND the same cycle as int_ack -> PEND[2]=1 and a second request for 20'h00102 follows.
REQ-035 SHALL be verified for masking and PEND W1C: MASK=8'h01, irq[0] pulses -> no int_in and cfg_rdata(PEND)=8'h01; PEND write 8'h01 -> PEND reads 0.
REQ-036 SHALL be verified for mid-operation reset: clr_n low in REQ -> int_in=0 asynchronously, MASK reads 8'hFF, no request after release until MASK is written.
